// File: rtl/iris_meta_pkg.sv
// Shared constants, FSM encoding and CRC parameters for the FW metadata packetizer.
// Packet: SYNC0 SYNC1 LEN major minor patch up[31:24..7:0] trailer (1B XOR or 2B CRC-16).
package iris_meta_pkg;

  localparam logic [7:0]  SYNC0_DEF     = 8'hA5;
  localparam logic [7:0]  SYNC1_DEF     = 8'h5A;
  localparam logic [7:0]  META_LEN      = 8'h07;
  localparam int          UPTIME_W_DEF  = 32;

  localparam int          PKT_BYTES_XOR = 11;
  localparam int          PKT_BYTES_CRC = 12;
  localparam int          IDX_W         = 4;

  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/iris_meta_crc16_byte.sv
// One-byte step of CRC-16/CCITT-FALSE (MSB first, no reflection), purely combinational.
module iris_meta_crc16_byte
  import iris_meta_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      acc = acc[15] ? ((acc << 1) ^ CRC_POLY) : (acc << 1);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/iris_fw_meta_packetizer.sv
// Serialises a framed FW-version + uptime packet over a byte valid/ready stream on request.
// Build macro IRIS_META_CRC16_EN selects a 2-byte CRC-16 trailer instead of the 1-byte XOR.
module iris_fw_meta_packetizer
  import iris_meta_pkg::*;
#(
  parameter logic [7:0] SYNC0    = SYNC0_DEF,
  parameter logic [7:0] SYNC1    = SYNC1_DEF,
  parameter int         UPTIME_W = UPTIME_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] fw_major,
  input  logic [7:0] fw_minor,
  input  logic [7:0] fw_patch,
  input  logic       tick,
  input  logic       req,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       done
);

`ifdef IRIS_META_CRC16_EN
  localparam int             PKT_BYTES = PKT_BYTES_CRC;
  localparam int             CHK_W     = 16;
  localparam logic [CHK_W-1:0] CHK_INIT = CRC_INIT;
`else
  localparam int             PKT_BYTES = PKT_BYTES_XOR;
  localparam int             CHK_W     = 8;
  localparam logic [CHK_W-1:0] CHK_INIT = '0;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [UPTIME_W-1:0] uptime_q, uptime_d;
  logic [UPTIME_W-1:0] snap_up_q, snap_up_d;
  logic [7:0]          snap_maj_q, snap_maj_d;
  logic [7:0]          snap_min_q, snap_min_d;
  logic [7:0]          snap_pat_q, snap_pat_d;
  logic [CHK_W-1:0]    chk_q, chk_d;
  logic [CHK_W-1:0]    chk_step;
  logic [7:0]          cur_byte;
  logic                start;

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = SYNC0;
      4'd1:    cur_byte = SYNC1;
      4'd2:    cur_byte = META_LEN;
      4'd3:    cur_byte = snap_maj_q;
      4'd4:    cur_byte = snap_min_q;
      4'd5:    cur_byte = snap_pat_q;
      4'd6:    cur_byte = snap_up_q[31:24];
      4'd7:    cur_byte = snap_up_q[23:16];
      4'd8:    cur_byte = snap_up_q[15:8];
      4'd9:    cur_byte = snap_up_q[7:0];
`ifdef IRIS_META_CRC16_EN
      4'd10:   cur_byte = chk_q[15:8];
      4'd11:   cur_byte = chk_q[7:0];
`else
      4'd10:   cur_byte = chk_q;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

`ifdef IRIS_META_CRC16_EN
  iris_meta_crc16_byte u_crc (
    .crc_in  (chk_q),
    .data    (cur_byte),
    .crc_out (chk_step)
  );
`else
  assign chk_step = chk_q ^ cur_byte;
`endif

  // Snapshot reads the pre-increment uptime, so a coincident tick lands after capture.
  assign uptime_d = uptime_q + UPTIME_W'(tick);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    chk_d      = chk_q;
    snap_up_d  = snap_up_q;
    snap_maj_d = snap_maj_q;
    snap_min_d = snap_min_q;
    snap_pat_d = snap_pat_q;
    start      = 1'b0;

    case (state_q)
      ST_IDLE: start = req;
      ST_SEND: begin
        if (req) pend_d = 1'b1;
        if (m_ready) begin
          if (idx_q >= 4'd2 && idx_q <= 4'd9) chk_d = chk_step;
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        // A req landing in the DONE cycle itself is folded into the pending restart.
        start = pend_q | req;
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d    = ST_SEND;
      idx_d      = '0;
      pend_d     = 1'b0;
      chk_d      = CHK_INIT;
      snap_up_d  = uptime_q;
      snap_maj_d = fw_major;
      snap_min_d = fw_minor;
      snap_pat_d = fw_patch;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      uptime_q   <= '0;
      snap_up_q  <= '0;
      snap_maj_q <= '0;
      snap_min_q <= '0;
      snap_pat_q <= '0;
      chk_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      uptime_q   <= uptime_d;
      snap_up_q  <= snap_up_d;
      snap_maj_q <= snap_maj_d;
      snap_min_q <= snap_min_d;
      snap_pat_q <= snap_pat_d;
      chk_q      <= chk_d;
    end
  end

  assign m_valid = (state_q == ST_SEND);
  assign m_data  = m_valid ? cur_byte : 8'h00;
  assign done    = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE) | pend_q;

endmodule

// File: tb/tb_iris_fw_meta_packetizer.sv
// Directed bench for iris_fw_meta_packetizer: vector table plus pending, wrap and reset sequences.
module tb_iris_fw_meta_packetizer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] fw_major, fw_minor, fw_patch;
  logic       tick, req, m_ready;
  logic [7:0] m_data;
  logic       m_valid, busy, done;

  always #5 clk = ~clk;

  iris_fw_meta_packetizer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .fw_major (fw_major),
    .fw_minor (fw_minor),
    .fw_patch (fw_patch),
    .tick     (tick),
    .req      (req),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

`ifdef IRIS_META_CRC16_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif

  typedef struct {
    bit          rst;
    logic [7:0]  maj;
    logic [7:0]  min;
    logic [7:0]  pat;
    int          ticks;
    bit          rnd;
    logic [87:0] exp;
  } vec_t;

  vec_t       vt [4];
  logic [7:0] exp_q [12];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic finish_exp();
`ifdef IRIS_META_CRC16_EN
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 2; i < 10; i++) c = crc_step(c, exp_q[i]);
    exp_q[10] = c[15:8];
    exp_q[11] = c[7:0];
`else
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < 10; i++) x = x ^ exp_q[i];
    exp_q[10] = x;
    exp_q[11] = 8'h00;
`endif
  endtask

  task automatic model_exp(input logic [7:0] ma, input logic [7:0] mi, input logic [7:0] pa,
                           input logic [31:0] up);
    exp_q[0] = 8'hA5; exp_q[1] = 8'h5A; exp_q[2] = 8'h07;
    exp_q[3] = ma;    exp_q[4] = mi;    exp_q[5] = pa;
    exp_q[6] = up[31:24]; exp_q[7] = up[23:16]; exp_q[8] = up[15:8]; exp_q[9] = up[7:0];
    finish_exp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic do_ticks(input int n);
    if (n > 0) begin
      @(negedge clk);
      tick = 1'b1;
      repeat (n) @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic send_req(input string name);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk({name, "_latency_valid"}, m_valid, 1);
  endtask

  // Collects NB bytes starting at the next falling edge; also checks stall stability and the DONE pulse.
  task automatic run_pkt(input bit rnd, input bit pend, input string name);
    int         got;
    int         cyc;
    logic       stall;
    logic [7:0] held;
    got = 0; cyc = 0; stall = 1'b0; held = 8'h00;
    while (got < NB && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk($sformatf("%s_hold_valid", name), m_valid, 1);
        chk($sformatf("%s_hold_data", name), m_data, held);
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        chk($sformatf("%s_byte%0d", name, got), m_data, exp_q[got]);
        got++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
    end
    if (got < NB) chk($sformatf("%s_timeout_bytes", name), 32'(got), 32'(NB));
    @(negedge clk);
    chk($sformatf("%s_done_pulse", name), done, 1);
    chk($sformatf("%s_done_valid", name), m_valid, 0);
    chk($sformatf("%s_done_busy", name), busy, 1);
    if (!pend) begin
      @(negedge clk);
      chk($sformatf("%s_after_done", name), done, 0);
      chk($sformatf("%s_after_busy", name), busy, 0);
      chk($sformatf("%s_after_valid", name), m_valid, 0);
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 8'h0B, 8'h00, 8'h01,   3, 1'b0, 88'hA5_5A_07_0B_00_01_00_00_00_03_0E};
    vt[1] = '{1'b0, 8'h01, 8'h02, 8'h03,   2, 1'b0, 88'hA5_5A_07_01_02_03_00_00_00_05_02};
    vt[2] = '{1'b0, 8'hFF, 8'h80, 8'h7F, 251, 1'b1, 88'hA5_5A_07_FF_80_7F_00_00_01_00_06};
    vt[3] = '{1'b1, 8'h0B, 8'h00, 8'h01,   3, 1'b1, 88'hA5_5A_07_0B_00_01_00_00_00_03_0E};

    reset_n = 1'b0; tick = 1'b0; req = 1'b0; m_ready = 1'b1;
    fw_major = 8'h00; fw_minor = 8'h00; fw_patch = 8'h00;
    #1;
    chk("reset_m_data", m_data, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #10;
    reset_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      if (vt[v].rst) do_reset();
      fw_major = vt[v].maj; fw_minor = vt[v].min; fw_patch = vt[v].pat;
      do_ticks(vt[v].ticks);
      for (int i = 0; i < 11; i++) exp_q[i] = vt[v].exp[87 - 8*i -: 8];
`ifdef IRIS_META_CRC16_EN
      finish_exp();
`endif
      send_req($sformatf("vec%0d", v));
      run_pkt(vt[v].rnd, 1'b0, $sformatf("vec%0d", v));
    end

    // Three reqs during SEND coalesce into one follow-on packet with a fresh snapshot.
    model_exp(8'h0B, 8'h00, 8'h01, 32'd3);
    send_req("pend1");
    fork
      run_pkt(1'b0, 1'b1, "pend1");
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); req = 1'b1;
          @(negedge clk); req = 1'b0;
        end
        fw_patch = 8'h09;
      end
    join
    model_exp(8'h0B, 8'h00, 8'h09, 32'd3);
    run_pkt(1'b0, 1'b0, "pend2");
    repeat (3) @(negedge clk);
    chk("pend_no_third_valid", m_valid, 0);
    chk("pend_no_third_busy", busy, 0);

    // Uptime at all-ones with a tick coinciding with acceptance.
    @(negedge clk);
    force dut.uptime_q = 32'hFFFF_FFFF;
    #1;
    release dut.uptime_q;
    tick = 1'b1; req = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0; req = 1'b0;
    chk("wrap_latency_valid", m_valid, 1);
    model_exp(8'h0B, 8'h00, 8'h09, 32'hFFFF_FFFF);
    run_pkt(1'b0, 1'b0, "wrap");
    model_exp(8'h0B, 8'h00, 8'h09, 32'h0000_0000);
    send_req("post_wrap");
    run_pkt(1'b0, 1'b0, "post_wrap");

    // Reset asserted mid-packet, after five bytes have been accepted.
    do_ticks(4);
    send_req("abort");
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_m_data", m_data, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_exp(8'h0B, 8'h00, 8'h09, 32'd0);
    send_req("post_reset");
    run_pkt(1'b0, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
